// File: rtl/idelay_tap_pkg.sv
// Shared constants and types for the IDELAY tap loader: register map, STATUS layout,
// AXI response codes and the sequencer state encoding.
package idelay_tap_pkg;

   localparam logic [31:0] CTRL_OFF   = 32'h00;
   localparam logic [31:0] STATUS_OFF = 32'h04;
   localparam logic [31:0] TAP_BASE   = 32'h40;
   localparam logic [31:0] RDBK_BASE  = 32'h80;

   localparam int unsigned ST_BUSY_BIT   = 0;
   localparam int unsigned ST_DONE_BIT   = 1;
   localparam int unsigned ST_ERROR_BIT  = 2;
   localparam int unsigned ST_ERRCH_LSB  = 8;
   localparam int unsigned ERR_CH_W      = 6;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      SeqIdle,
      SeqVtcOff,
      SeqLoad,
      SeqSettle,
      SeqCheck,
      SeqVtcOn,
      SeqFin
   } seq_state_t;

endpackage

// File: rtl/idelay_tap_seq.sv
// Per-channel IDELAY load sequencer: drops EN_VTC, pulses LOAD with the shadow tap,
// waits, compares CNTVALUEOUT and restores EN_VTC, walking channels 0..NUM_CH-1.
module idelay_tap_seq
   import idelay_tap_pkg::*;
#(
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned TAP_W     = 9,
   parameter int unsigned VTC_WAIT  = 8,
   parameter int unsigned LOAD_WAIT = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [NUM_CH*TAP_W-1:0]   shadow_i,
   input  logic [NUM_CH*TAP_W-1:0]   rdbk_i,
   output logic [NUM_CH-1:0]         load_o,
   output logic [NUM_CH-1:0]         en_vtc_o,
   output logic [NUM_CH*TAP_W-1:0]   cntvaluein_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [ERR_CH_W-1:0]       err_ch_o
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned MAXW  = (VTC_WAIT > LOAD_WAIT) ? VTC_WAIT : LOAD_WAIT;
   localparam int unsigned CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

   seq_state_t                 state_q, state_d;
   logic [CH_W-1:0]            ch_q, ch_d, ch_nxt;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [NUM_CH*TAP_W-1:0]    cval_q, cval_d;
   logic                       busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [ERR_CH_W-1:0]        err_ch_q, err_ch_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= SeqIdle;
         ch_q     <= '0;
         cnt_q    <= '0;
         cval_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         err_ch_q <= '0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         cnt_q    <= cnt_d;
         cval_q   <= cval_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         err_ch_q <= err_ch_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      cval_d   = cval_q;
      busy_d   = busy_q;
      done_d   = done_q;
      error_d  = error_q;
      err_ch_d = err_ch_q;
      ch_nxt   = ch_q + CH_W'(1);
      unique case (state_q)
         SeqIdle: begin
            if (start_i) begin
               state_d  = SeqVtcOff;
               ch_d     = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               error_d  = 1'b0;
               err_ch_d = '0;
               cval_d[0 +: TAP_W] = shadow_i[0 +: TAP_W];
            end
         end
         SeqVtcOff: begin
            if (cnt_q == CNT_W'(VTC_WAIT - 1)) begin
               state_d = SeqLoad;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SeqLoad: state_d = SeqSettle;
         SeqSettle: begin
            if (cnt_q == CNT_W'(LOAD_WAIT - 1)) begin
               state_d = SeqCheck;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SeqCheck: begin
            // Only the first failing channel is latched; later ones just keep ERROR set.
            if (rdbk_i[int'(ch_q)*TAP_W +: TAP_W] != cval_q[int'(ch_q)*TAP_W +: TAP_W]) begin
               error_d = 1'b1;
               if (!error_q) err_ch_d = ERR_CH_W'(ch_q);
            end
            state_d = SeqVtcOn;
         end
         SeqVtcOn: begin
            if (ch_q == CH_W'(NUM_CH - 1)) begin
               state_d = SeqFin;
            end else begin
               ch_d    = ch_nxt;
               state_d = SeqVtcOff;
               cval_d[int'(ch_nxt)*TAP_W +: TAP_W] = shadow_i[int'(ch_nxt)*TAP_W +: TAP_W];
            end
         end
         SeqFin: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = SeqIdle;
         end
         default: state_d = SeqIdle;
      endcase
   end

   // Strobes derive from registered state only, so reset forces them immediately.
   always_comb begin
      load_o   = '0;
      en_vtc_o = '1;
      if (state_q == SeqLoad) load_o[ch_q] = 1'b1;
      if (state_q inside {SeqVtcOff, SeqLoad, SeqSettle, SeqCheck}) en_vtc_o[ch_q] = 1'b0;
   end

   assign cntvaluein_o = cval_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign err_ch_o     = err_ch_q;

endmodule

// File: rtl/idelay_tap_loader_axil.sv
// AXI4-Lite register file holding per-channel IDELAY taps, with a START-triggered
// sequencer that loads and verifies each lane's IDELAYE3.
module idelay_tap_loader_axil
   import idelay_tap_pkg::*;
#(
   parameter int unsigned NUM_CH    = 16,
   parameter int unsigned TAP_W     = 9,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned VTC_WAIT  = 8,
   parameter int unsigned LOAD_WAIT = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_W-1:0]       S_AXI_AWADDR,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [31:0]             S_AXI_WDATA,
   input  logic [3:0]              S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [ADDR_W-1:0]       S_AXI_ARADDR,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [31:0]             S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [NUM_CH*TAP_W-1:0] TAP_CNTVALUEIN,
   output logic [NUM_CH-1:0]       TAP_LOAD,
   output logic [NUM_CH-1:0]       TAP_EN_VTC,
   input  logic [NUM_CH*TAP_W-1:0] TAP_CNTVALUEOUT
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                    init_q;
   logic                    aw_full_q, aw_full_d, w_full_q, w_full_d;
   logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
   logic [TAP_W-1:0]        wdata_q, wdata_d;
   logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [NUM_CH*TAP_W-1:0] shadow_q, shadow_d;

   logic                    commit, start, busy, done, error;
   logic [ERR_CH_W-1:0]     err_ch;
   logic [31:0]             wr_a, wr_off, rd_a, rd_off, rb_off, status_word;
   logic                    wr_is_tap, rd_is_tap, rd_is_rdbk;
   logic [CH_W-1:0]         wr_idx, rd_idx, rb_idx;
   logic                    unused_bits;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         init_q    <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         shadow_q  <= '0;
      end else begin
         init_q    <= 1'b1;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         shadow_q  <= shadow_d;
      end
   end

   // READY is held low during and for the first cycle after reset.
   assign S_AXI_AWREADY = init_q && !aw_full_q && !bvalid_q;
   assign S_AXI_WREADY  = init_q && !w_full_q && !bvalid_q;
   assign S_AXI_ARREADY = init_q && !rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;

   always_comb begin
      wr_a = '0;
      wr_a[ADDR_W-1:0] = awaddr_q;
      wr_a[1:0] = 2'b00;
      wr_off    = wr_a - TAP_BASE;
      wr_is_tap = (wr_a >= TAP_BASE) && (wr_a < TAP_BASE + 4 * NUM_CH);
      wr_idx    = wr_off[CH_W+1:2];

      rd_a = '0;
      rd_a[ADDR_W-1:0] = S_AXI_ARADDR;
      rd_a[1:0]  = 2'b00;
      rd_off     = rd_a - TAP_BASE;
      rb_off     = rd_a - RDBK_BASE;
      rd_is_tap  = (rd_a >= TAP_BASE) && (rd_a < TAP_BASE + 4 * NUM_CH);
      rd_is_rdbk = (rd_a >= RDBK_BASE) && (rd_a < RDBK_BASE + 4 * NUM_CH);
      rd_idx     = rd_off[CH_W+1:2];
      rb_idx     = rb_off[CH_W+1:2];
   end

   assign commit = aw_full_q && w_full_q;
   assign start  = commit && (wr_a == CTRL_OFF) && wdata_q[0] && !busy;

   always_comb begin
      aw_full_d = aw_full_q;
      w_full_d  = w_full_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      shadow_d  = shadow_q;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
         aw_full_d = 1'b1;
         awaddr_d  = S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
         w_full_d = 1'b1;
         wdata_d  = S_AXI_WDATA[TAP_W-1:0];
      end
      if (S_AXI_BVALID && S_AXI_BREADY) bvalid_d = 1'b0;
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         if (wr_is_tap) begin
            if (busy) bresp_d = RESP_SLVERR;
            else shadow_d[int'(wr_idx)*TAP_W +: TAP_W] = wdata_q;
         end
      end
   end

   always_comb begin
      status_word = '0;
      status_word[ST_BUSY_BIT]  = busy;
      status_word[ST_DONE_BIT]  = done;
      status_word[ST_ERROR_BIT] = error;
      status_word[ST_ERRCH_LSB +: ERR_CH_W] = err_ch;
   end

   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (S_AXI_RVALID && S_AXI_RREADY) rvalid_d = 1'b0;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         if (rd_a == STATUS_OFF) begin
            rdata_d = status_word;
         end else if (rd_is_tap) begin
            rdata_d[TAP_W-1:0] = shadow_q[int'(rd_idx)*TAP_W +: TAP_W];
         end else if (rd_is_rdbk) begin
            rdata_d[TAP_W-1:0] = TAP_CNTVALUEOUT[int'(rb_idx)*TAP_W +: TAP_W];
         end
      end
   end

   assign unused_bits = ^{S_AXI_WSTRB, S_AXI_WDATA[31:TAP_W], wr_off, rd_off, rb_off};

   idelay_tap_seq #(
      .NUM_CH    (NUM_CH),
      .TAP_W     (TAP_W),
      .VTC_WAIT  (VTC_WAIT),
      .LOAD_WAIT (LOAD_WAIT)
   ) u_seq (
      .clk_i        (ACLK),
      .rst_i        (ARESET),
      .start_i      (start),
      .shadow_i     (shadow_q),
      .rdbk_i       (TAP_CNTVALUEOUT),
      .load_o       (TAP_LOAD),
      .en_vtc_o     (TAP_EN_VTC),
      .cntvaluein_o (TAP_CNTVALUEIN),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error),
      .err_ch_o     (err_ch)
   );

endmodule
